// File: rtl/execute_retire.sv
// rtl/execute_retire.sv - execute-to-retire stage: branch resolve, next PC, registered writeback, retire counter
// Optional feature macro: EXECUTE_RETIRE_MISALIGN_TRAP_EN (adds the misaligned output and suppresses misaligned redirects)
module execute_retire #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         decode_opcode,
  input  logic [2:0]         decode_funct3,
  input  logic [4:0]         decode_rd,
  input  logic [31:0]        decode_imm,
  input  logic [31:0]        decode_pc,
  input  logic [31:0]        alu_rd_val,
  input  logic               alu_lt,
  input  logic               alu_ltu,
  input  logic               alu_eq,
  input  logic               execute_valid,
  input  logic               retire_ready,
  output logic               rd_write_en,
  output logic [4:0]         rd_num,
  output logic [31:0]        rd_val,
  output logic [31:0]        pc_next,
  output logic               pc_redirect,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired_count,
`ifdef EXECUTE_RETIRE_MISALIGN_TRAP_EN
  output logic               misaligned,
`endif
  output logic               processing,
  output logic               valid
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;

  logic [31:0] pc4;
  logic [31:0] pc_target;
  logic        br_taken;
  logic        c_write;
  logic [31:0] c_rd_val;
  logic [31:0] c_pc_next;
  logic        c_redirect;
  logic        c_illegal;
  logic        c_misaligned;
  logic        capture;
  logic        retire;

  // A new result is taken when the stage is empty or the held one leaves this same cycle.
  assign capture = execute_valid && ((state == IDLE) || retire_ready);
  assign retire  = (state == HOLD) && retire_ready;

  // Decode the executing instruction into the values the stage will hold.
  always_comb begin
    pc4          = decode_pc + 32'd4;
    pc_target    = decode_pc + decode_imm;
    br_taken     = 1'b0;
    c_write      = 1'b0;
    c_rd_val     = alu_rd_val;
    c_pc_next    = pc4;
    c_redirect   = 1'b0;
    c_illegal    = 1'b0;
    c_misaligned = 1'b0;

    case (decode_opcode)
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: begin
        c_write = 1'b1;
      end
      OPC_JAL: begin
        c_write    = 1'b1;
        c_rd_val   = pc4;
        c_pc_next  = pc_target;
        c_redirect = 1'b1;
      end
      OPC_JALR: begin
        c_write    = 1'b1;
        c_rd_val   = pc4;
        c_pc_next  = alu_rd_val & ~32'h1;
        c_redirect = 1'b1;
      end
      OPC_BRANCH: begin
        case (decode_funct3)
          3'b000:  br_taken = alu_eq;
          3'b001:  br_taken = !alu_eq;
          3'b100:  br_taken = alu_lt;
          3'b101:  br_taken = !alu_lt;
          3'b110:  br_taken = alu_ltu;
          3'b111:  br_taken = !alu_ltu;
          default: c_illegal = 1'b1;
        endcase
        if (br_taken) begin
          c_pc_next  = pc_target;
          c_redirect = 1'b1;
        end
      end
      default: begin
        c_illegal = 1'b1;
      end
    endcase

    // x0 is never written, but rd_num/rd_val still carry the decoded values.
    if (decode_rd == 5'd0) begin
      c_write = 1'b0;
    end

`ifdef EXECUTE_RETIRE_MISALIGN_TRAP_EN
    // A redirect to a non-word-aligned target traps instead of writing or redirecting.
    if (c_redirect && (c_pc_next[1:0] != 2'b00)) begin
      c_misaligned = 1'b1;
      c_write      = 1'b0;
      c_redirect   = 1'b0;
    end
`endif
  end

  // Stage FSM with registered outputs and the retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= 1'b0;
      processing    <= 1'b0;
      rd_write_en   <= 1'b0;
      rd_num        <= 5'd0;
      rd_val        <= 32'd0;
      pc_next       <= RESET_PC;
      pc_redirect   <= 1'b0;
      illegal       <= 1'b0;
      retired_count <= '0;
`ifdef EXECUTE_RETIRE_MISALIGN_TRAP_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      if (capture) begin
        state       <= HOLD;
        valid       <= 1'b1;
        processing  <= 1'b1;
        rd_write_en <= c_write;
        rd_num      <= decode_rd;
        rd_val      <= c_rd_val;
        pc_next     <= c_pc_next;
        pc_redirect <= c_redirect;
        illegal     <= c_illegal;
`ifdef EXECUTE_RETIRE_MISALIGN_TRAP_EN
        misaligned  <= c_misaligned;
`endif
      end else if (retire) begin
        // Emptying: drop the action flags, keep the data fields for observability.
        state       <= IDLE;
        valid       <= 1'b0;
        processing  <= 1'b0;
        rd_write_en <= 1'b0;
        pc_redirect <= 1'b0;
        illegal     <= 1'b0;
`ifdef EXECUTE_RETIRE_MISALIGN_TRAP_EN
        misaligned  <= 1'b0;
`endif
      end

      if (retire) begin
        retired_count <= retired_count + COUNT_W'(1);
      end
    end
  end

`ifndef EXECUTE_RETIRE_MISALIGN_TRAP_EN
  // Only consumed when the misalignment trap is built in.
  logic unused_misaligned;
  assign unused_misaligned = c_misaligned;
`endif

endmodule
